// File: rtl/xorshift_pkg.sv
// Shared xorshift64 definitions: default seed, step function, checker states
// and a saturating counter helper.
package xorshift_pkg;

   localparam logic [63:0] XORSHIFT_DEFAULT_SEED = 64'h0000_0000_0000_0001;

   typedef enum logic [0:0] {
      RUN  = 1'b0,
      DONE = 1'b1
   } chk_state_e;

   // One xorshift64 step with logical shifts, 13/7/17 triple.
   function automatic logic [63:0] xorshift64_next(input logic [63:0] x);
      logic [63:0] v;
      v = x ^ (x << 6'd13);
      v = v ^ (v >> 6'd7);
      v = v ^ (v << 6'd17);
      return v;
   endfunction

   function automatic logic [31:0] sat_inc32(input logic [31:0] c);
      return (c == 32'hFFFF_FFFF) ? c : (c + 32'd1);
   endfunction

endpackage

// File: rtl/xorshift_checker_if.sv
// Beat bus from a CPU random-data source into its checker; no backpressure.
interface xorshift_checker_if;
   logic        data_vld;
   logic [63:0] data;

   modport master (
      output data_vld,
      output data
   );

   modport slave (
      input data_vld,
      input data
   );
endinterface

// File: rtl/xorshift64_gen.sv
// xorshift64 generator register: loads step(seed) in reset, steps on advance.
module xorshift64_gen
   import xorshift_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [63:0] i_seed,
   input  logic        i_advance,
   output logic [63:0] o_value
);

   logic [63:0] r_value;

   // Generator state holds the value the next beat must carry
   always_ff @(posedge clk) begin
      if (rst) begin
         r_value <= xorshift64_next(i_seed);
      end else if (i_advance) begin
         r_value <= xorshift64_next(r_value);
      end else begin
         r_value <= r_value;
      end
   end

   assign o_value = r_value;

endmodule

// File: rtl/xorshift_checker.sv
// Checks one CPU's beat stream against a regenerated xorshift64 sequence.
// Optional trace output: define XORSHIFT_CHECKER_DISPLAY_EN.
module xorshift_checker
   import xorshift_pkg::*;
#(
   parameter int unsigned TRANSACTION_NB = 16,
   parameter logic [63:0] SEED_BASE      = XORSHIFT_DEFAULT_SEED
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       i_cpu_index,
   xorshift_checker_if.slave s_beat,
   output logic [63:0]       o_expected,
   output logic [31:0]       o_match_cnt,
   output logic [31:0]       o_err_cnt,
   output logic              o_err,
   output logic [31:0]       o_first_err_idx,
   output logic              o_overrun,
   output logic              o_done
);

   localparam logic [31:0] TXN_NB = 32'(TRANSACTION_NB);

   chk_state_e  r_state;
   chk_state_e  w_state_nxt;
   logic [31:0] r_beat_idx;
   logic [31:0] r_match_cnt;
   logic [31:0] r_err_cnt;
   logic [31:0] r_first_err_idx;
   logic        r_err;
   logic        r_overrun;

   logic [63:0] w_seed_sum;
   logic [63:0] w_seed;
   logic        w_beat_run;
   logic        w_beat_done;
   logic        w_mismatch;
   logic        w_err_evt;
   logic        w_last_beat;

   // Seed derivation; an all-zero seed would lock xorshift at zero
   always_comb begin
      w_seed_sum = SEED_BASE + {32'd0, i_cpu_index};
      if (w_seed_sum == 64'd0) begin
         w_seed = XORSHIFT_DEFAULT_SEED;
      end else begin
         w_seed = w_seed_sum;
      end
   end

   assign w_beat_run  = s_beat.data_vld && (r_state == RUN);
   assign w_beat_done = s_beat.data_vld && (r_state == DONE);
   assign w_mismatch  = w_beat_run && (s_beat.data != o_expected);
   assign w_err_evt   = w_mismatch || w_beat_done;
   assign w_last_beat = w_beat_run && ((r_beat_idx + 32'd1) == TXN_NB);

   xorshift64_gen u_gen (
      .clk       (clk),
      .rst       (rst),
      .i_seed    (w_seed),
      .i_advance (w_beat_run),
      .o_value   (o_expected)
   );

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= RUN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM next state: leave RUN once the final expected beat is accepted
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         RUN: begin
            if (w_last_beat) begin
               w_state_nxt = DONE;
            end else begin
               w_state_nxt = RUN;
            end
         end
         DONE:    w_state_nxt = DONE;
         default: w_state_nxt = RUN;
      endcase
   end

   // Beat bookkeeping: counters, sticky flags and first-error capture
   always_ff @(posedge clk) begin
      if (rst) begin
         r_beat_idx      <= 32'd0;
         r_match_cnt     <= 32'd0;
         r_err_cnt       <= 32'd0;
         r_first_err_idx <= 32'd0;
         r_err           <= 1'b0;
         r_overrun       <= 1'b0;
      end else begin
         if (w_beat_run) begin
            r_beat_idx <= sat_inc32(r_beat_idx);
         end
         if (w_beat_run && !w_mismatch) begin
            r_match_cnt <= sat_inc32(r_match_cnt);
         end
         if (w_err_evt) begin
            r_err_cnt <= sat_inc32(r_err_cnt);
            if (!r_err) begin
               r_err           <= 1'b1;
               r_first_err_idx <= r_beat_idx;
            end
         end
         if (w_beat_done) begin
            r_overrun <= 1'b1;
         end
      end
   end

   assign o_match_cnt     = r_match_cnt;
   assign o_err_cnt       = r_err_cnt;
   assign o_err           = r_err;
   assign o_first_err_idx = r_first_err_idx;
   assign o_overrun       = r_overrun;
   assign o_done          = (r_state == DONE);

`ifdef XORSHIFT_CHECKER_DISPLAY_EN
   logic r_done_reported;

   // Trace each beat outcome and report once after reaching DONE
   always_ff @(posedge clk) begin
      if (rst) begin
         r_done_reported <= 1'b0;
      end else begin
         if (w_beat_run && !w_mismatch) begin
            $display("[chk_%0d] beat %0d match 0x%016h",
                     i_cpu_index, r_beat_idx, s_beat.data);
         end else if (w_mismatch) begin
            $display("[chk_%0d] error beat %0d expected 0x%016h received 0x%016h",
                     i_cpu_index, r_beat_idx, o_expected, s_beat.data);
         end else if (w_beat_done) begin
            $display("[chk_%0d] error overrun beat %0d received 0x%016h",
                     i_cpu_index, r_beat_idx, s_beat.data);
         end
         if ((r_state == DONE) && !r_done_reported) begin
            r_done_reported <= 1'b1;
            $display("[chk_%0d] done matches=%0d errors=%0d overrun=%0d",
                     i_cpu_index, r_match_cnt, r_err_cnt, r_overrun);
         end
      end
   end
`endif

endmodule

// File: tb/tb_xorshift_checker.sv
// Randomized bench for xorshift_checker: two instances (SEED_BASE 1 and 0)
// checked every cycle against a beat-level reference model.
module tb_xorshift_checker;

   localparam int N = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] cpu_idx_a = 32'd0;
   bit          chk_en = 1'b0;
   int          checks = 0;
   int          failures = 0;

   xorshift_checker_if bus_a ();
   xorshift_checker_if bus_b ();

   logic [63:0] o_exp   [2];
   logic [31:0] o_match [2];
   logic [31:0] o_errc  [2];
   logic        o_err   [2];
   logic [31:0] o_first [2];
   logic        o_over  [2];
   logic        o_done  [2];

   xorshift_checker #(.TRANSACTION_NB(N), .SEED_BASE(64'h1)) dut_a (
      .clk(clk), .rst(rst), .i_cpu_index(cpu_idx_a), .s_beat(bus_a),
      .o_expected(o_exp[0]), .o_match_cnt(o_match[0]), .o_err_cnt(o_errc[0]),
      .o_err(o_err[0]), .o_first_err_idx(o_first[0]), .o_overrun(o_over[0]),
      .o_done(o_done[0]));

   xorshift_checker #(.TRANSACTION_NB(N), .SEED_BASE(64'h0)) dut_b (
      .clk(clk), .rst(rst), .i_cpu_index(32'd0), .s_beat(bus_b),
      .o_expected(o_exp[1]), .o_match_cnt(o_match[1]), .o_err_cnt(o_errc[1]),
      .o_err(o_err[1]), .o_first_err_idx(o_first[1]), .o_overrun(o_over[1]),
      .o_done(o_done[1]));

   always #5 clk = ~clk;

   // Reference model: per-instance beat tally and next expected value
   logic [63:0] m_exp   [2];
   logic [31:0] m_beats [2];
   logic [31:0] m_match [2];
   logic [31:0] m_errc  [2];
   logic [31:0] m_first [2];
   bit          m_err   [2];
   bit          m_over  [2];

   // xorshift64 step written with multiply/divide instead of shifts
   function automatic logic [63:0] ref_xs(input logic [63:0] x);
      logic [63:0] v;
      v = x ^ (x * 64'd8192);
      v = v ^ (v / 64'd128);
      v = v ^ (v * 64'd131072);
      return v;
   endfunction

   function automatic logic [63:0] seed_of(input logic [63:0] base, input logic [31:0] idx);
      logic [63:0] s;
      s = base + {32'd0, idx};
      return (s == 64'd0) ? 64'd1 : s;
   endfunction

   task automatic model_reset(input int d, input logic [63:0] s);
      m_exp[d] = ref_xs(s);
      m_beats[d] = 32'd0; m_match[d] = 32'd0; m_errc[d] = 32'd0;
      m_first[d] = 32'd0; m_err[d] = 1'b0; m_over[d] = 1'b0;
   endtask

   task automatic model_beat(input int d, input logic [63:0] data);
      if (m_beats[d] < N) begin
         if (data == m_exp[d]) begin
            m_match[d] = m_match[d] + 32'd1;
         end else begin
            m_errc[d] = m_errc[d] + 32'd1;
            if (!m_err[d]) begin m_err[d] = 1'b1; m_first[d] = m_beats[d]; end
         end
         m_beats[d] = m_beats[d] + 32'd1;
         m_exp[d] = ref_xs(m_exp[d]);
      end else begin
         m_over[d] = 1'b1;
         m_errc[d] = m_errc[d] + 32'd1;
         if (!m_err[d]) begin m_err[d] = 1'b1; m_first[d] = m_beats[d]; end
      end
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%016h required=0x%016h at %0t", nm, act, req, $time);
      end
   endtask

   // Per-cycle comparison of both instances against the model
   always @(negedge clk) begin
      if (chk_en) begin
         for (int d = 0; d < 2; d++) begin
            chk($sformatf("dut%0d_expected", d), o_exp[d], m_exp[d]);
            chk($sformatf("dut%0d_match_cnt", d), 64'(o_match[d]), 64'(m_match[d]));
            chk($sformatf("dut%0d_err_cnt", d), 64'(o_errc[d]), 64'(m_errc[d]));
            chk($sformatf("dut%0d_err", d), 64'(o_err[d]), 64'(m_err[d]));
            if (m_err[d]) chk($sformatf("dut%0d_first_err_idx", d), 64'(o_first[d]), 64'(m_first[d]));
            chk($sformatf("dut%0d_overrun", d), 64'(o_over[d]), 64'(m_over[d]));
            chk($sformatf("dut%0d_done", d), 64'(o_done[d]), 64'(m_beats[d] >= N));
         end
      end
   end

   // One clock: drive inputs, let the DUT sample, then update the model
   task automatic cycle(input bit r, input bit v, input logic [63:0] mask_a, input logic [63:0] mask_b);
      rst = r;
      bus_a.data_vld = v; bus_a.data = m_exp[0] ^ mask_a;
      bus_b.data_vld = v; bus_b.data = m_exp[1] ^ mask_b;
      @(posedge clk);
      if (r) begin
         model_reset(0, seed_of(64'h1, cpu_idx_a));
         model_reset(1, seed_of(64'h0, 32'd0));
      end else if (v) begin
         model_beat(0, bus_a.data);
         model_beat(1, bus_b.data);
      end
      #1;
   endtask

   task automatic do_reset();
      cycle(1'b1, 1'b1, 64'(|$urandom()), 64'd0);
      cycle(1'b1, 1'b1, 64'd0, 64'd5);
   endtask

   initial begin
      int k;
      logic [63:0] msk;
      bus_a.data_vld = 1'b0; bus_a.data = 64'd0;
      bus_b.data_vld = 1'b0; bus_b.data = 64'd0;
      for (int d = 0; d < 2; d++) model_reset(d, 64'd1);
      #1;

      // Reset with cpu_index 0; SEED_BASE 0 instance exercises the zero guard
      do_reset();
      chk_en = 1'b1;
      chk("pin_reset_exp_a", o_exp[0], 64'h0000_0000_4082_2041);
      chk("pin_reset_exp_b", o_exp[1], 64'h0000_0000_4082_2041);
      chk("pin_model_exp", m_exp[0], 64'h0000_0000_4082_2041);
      chk("pin_reset_done", 64'(o_done[0]), 64'd0);

      // 16 correct back-to-back beats
      for (int i = 0; i < N; i++) begin
         cycle(1'b0, 1'b1, 64'd0, 64'd0);
         if (i == 0) begin
            chk("pin_first_match", 64'(o_match[0]), 64'd1);
            chk("pin_first_err", 64'(o_err[0]), 64'd0);
         end
         if (i == N - 2) chk("pin_done_early", 64'(o_done[0]), 64'd0);
      end
      chk("pin_done", 64'(o_done[0]), 64'd1);
      chk("pin_match16", 64'(o_match[0]), 64'd16);
      chk("pin_errc0", 64'(o_errc[0]), 64'd0);

      // Two overrun beats after DONE
      cycle(1'b0, 1'b1, 64'd0, 64'd0);
      cycle(1'b0, 1'b1, 64'd0, 64'd0);
      chk("pin_overrun", 64'(o_over[0]), 64'd1);
      chk("pin_overrun_errc", 64'(o_errc[0]), 64'd2);
      chk("pin_overrun_first", 64'(o_first[0]), 64'd16);
      chk("pin_overrun_match", 64'(o_match[0]), 64'd16);

      // Corrupt beat 5 with random idle gaps
      do_reset();
      k = 0;
      for (int c = 0; c < 200 && k < N; c++) begin
         if ($urandom_range(0, 2) != 0) begin
            msk = (k == 5) ? 64'd1 : 64'd0;
            cycle(1'b0, 1'b1, msk, msk);
            k++;
         end else begin
            cycle(1'b0, 1'b0, 64'd0, 64'd0);
         end
      end
      chk("pin_corrupt_err", 64'(o_err[0]), 64'd1);
      chk("pin_corrupt_first", 64'(o_first[0]), 64'd5);
      chk("pin_corrupt_errc", 64'(o_errc[0]), 64'd1);
      chk("pin_corrupt_match", 64'(o_match[0]), 64'd15);
      chk("pin_corrupt_done", 64'(o_done[0]), 64'd1);

      // Reset after beat 7, then replay from beat 0 with a random index
      cpu_idx_a = $urandom();
      do_reset();
      for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 64'd0, 64'd0);
      do_reset();
      chk("pin_restart_match", 64'(o_match[0]), 64'd0);
      for (int i = 0; i < N; i++) cycle(1'b0, 1'b1, 64'd0, 64'd0);
      chk("pin_replay_match", 64'(o_match[0]), 64'd16);
      chk("pin_replay_errc", 64'(o_errc[0]), 64'd0);

      // Randomized runs: gaps, sparse corruption, occasional reset, overruns
      for (int run = 0; run < 20; run++) begin
         cpu_idx_a = (run % 4 == 0) ? 32'hFFFF_FFFF : $urandom();
         do_reset();
         for (int c = 0; c < 40; c++) begin
            msk = ($urandom_range(0, 7) == 0) ? {$urandom(), $urandom()} : 64'd0;
            if ($urandom_range(0, 39) == 0) begin
               cycle(1'b1, $urandom_range(0, 1) == 1, msk, msk);
            end else begin
               cycle(1'b0, $urandom_range(0, 3) != 0, msk, {msk[31:0], msk[63:32]});
            end
         end
      end

      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/xorshift_checker.md
# xorshift_checker

Receiving end of a CPU's random-data stream. Each instance sits beside one `cpu` instance inside the per-CPU generate loop of the top-level testbench and consumes that CPU's `data_vld`/`data` beats. It regenerates the expected xorshift64 sequence from a seed derived from the CPU index and checks every beat against it. It counts matches and errors and asserts `done` once the configured number of transactions has been received, so `top` can gate `$finish` on checked completion instead of raw traffic.

## Interface
- `TRANSACTION_NB`, default 16: number of beats expected per run (≥1).
- `SEED_BASE`, default 64'h1: seed = `SEED_BASE + cpu_index` (64-bit add, zero-extended index).
- `clk` input 1: clock; all logic on posedge.
- `rst` input 1: synchronous, active-high reset.
- `cpu_index` input 32: CPU index; must be stable while `rst` is high.
- `data_vld` input 1: beat valid; one beat per cycle with `data_vld`=1; no backpressure.
- `data` input 64: beat payload.
- `expected` output 64: value the next beat must carry.
- `match_cnt` output 32: beats that matched.
- `err_cnt` output 32: mismatching beats plus overrun beats.
- `err` output 1: sticky; set on the first mismatch or overrun.
- `first_err_idx` output 32: beat index (0-based) of the first error; valid when `err`=1.
- `overrun` output 1: sticky; a beat arrived while in DONE.
- `done` output 1: high in DONE state.

## Operation
- FSM states are RUN and DONE. Reset enters RUN.
- While `rst`=1, the generator loads seed s. s = `SEED_BASE + cpu_index`. If s==0, s is forced to 64'h1.
- `expected` = xorshift64(state), computed as: x ^= x<<13; x ^= x>>7; x ^= x<<17. All arithmetic is 64-bit with logical shifts.
- A beat in RUN compares `data` with `expected`. The generator then advances by one step, regardless of the compare result, so a single corrupt beat does not desynchronise the check.
  - Match: `match_cnt`++.
  - Mismatch: `err_cnt`++. If `err` was 0, set `err` and set `first_err_idx` = `beat_idx`.
- `beat_idx` is an internal counter of beats accepted in RUN. When it reaches `TRANSACTION_NB`, the FSM moves RUN→DONE.
- A beat in DONE is not compared and does not advance the generator. It sets `overrun`, increments `err_cnt`, and sets `err`/`first_err_idx` if no error has been recorded yet. The FSM stays in DONE.
- Counters saturate at 32'hFFFF_FFFF.

## Timing
- Reset values: `expected` = xorshift64(s), all counters 0, `err`=0, `overrun`=0, `first_err_idx`=0, `done`=0.
- `expected` is valid in the first cycle after `rst` drops.
- Compare is combinational against registered `expected`. All outputs update on the clock edge that samples the beat, so they are visible 1 cycle after the beat.
- `done` rises in the cycle after the last (`TRANSACTION_NB`-th) beat is sampled.
- Back-to-back beats every cycle are supported.
- `rst` mid-run discards all state. The checker reseeds and restarts from beat 0.
- `data_vld`=1 in the same cycle as `rst`=1 is ignored.

## Configuration
- `XORSHIFT_CHECKER_DISPLAY_EN` defined: the block issues `$display("[chk_%0d] ...")` per matched beat and per error. Error messages give the beat index, expected value and received value. A single summary line is printed on entry to DONE.
- Undefined: no display statements are compiled. Behaviour is otherwise identical.

## Structure
- Package `xorshift_pkg` holds:
  - `XORSHIFT_DEFAULT_SEED` = 64'h1.
  - Function `xorshift64_next(logic [63:0])`.
  - Enum `chk_state_e {RUN, DONE}`.
- The package is shared so that `cpu` uses the same `xorshift64_next`.
- Sub-module `xorshift64_gen` (inputs: `clk`, `rst`, `seed`, `advance`; output: `value`) holds the generator register. The checker keeps the FSM, counters and flags.

## Test plan
- Reset with `SEED_BASE`=1, `cpu_index`=0 → `expected`=64'h0000_0000_4082_2041. Send that value → `match_cnt`=1, `err`=0.
- Feed 16 correct back-to-back beats → `done`=1 exactly 1 cycle after beat 15. Final state: `match_cnt`=16, `err_cnt`=0.
- Corrupt beat 5 (flip bit 0), others correct → `err`=1, `first_err_idx`=5, `err_cnt`=1, `match_cnt`=15, `done`=1.
- `SEED_BASE`=0, `cpu_index`=0 → zero guard applies; first `expected`=64'h4082_2041.
- After `done`, send 2 more beats → `overrun`=1, `err_cnt`=2, `first_err_idx`=16, `match_cnt` unchanged.
- Assert `rst` after beat 7 of 16, then replay from beat 0 → counters restart at 0 and all 16 beats match.
